// File: rtl/vga_timing_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_pkg
// Shared 640x480@60 timing constants and derived totals, plus the lock state
// encoding used by the receive-side sync monitor. The VGA controller imports
// the same package so generator and monitor agree on one set of numbers.
// -----------------------------------------------------------------------------
package vga_timing_pkg;

  localparam int H_ACTIVE    = 640;
  localparam int H_FP        = 16;
  localparam int H_SYNC      = 96;
  localparam int H_BP        = 48;
  localparam int V_ACTIVE    = 480;
  localparam int V_FP        = 10;
  localparam int V_SYNC      = 2;
  localparam int V_BP        = 33;
  localparam int LOCK_FRAMES = 2;

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;  // 800
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;  // 525
  localparam int HS_POS  = H_ACTIVE + H_FP;                  // 656
  localparam int VS_POS  = V_ACTIVE + V_FP;                  // 490

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    ALIGN  = 2'd1,
    LOCKED = 2'd2
  } mon_state_t;

endpackage

// File: rtl/vga_edge_detect.sv
// -----------------------------------------------------------------------------
// vga_edge_detect
// Registers one active-low sync input, keeps a delayed copy and strobes on a
// high-to-low transition between the two.
//   clk  : pixel clock
//   rst  : synchronous active-high reset (both taps return to idle-high)
//   d    : raw sync input
//   fall : high for the one cycle in which the stage-1 sample is the first
//          low sample after a high one
// -----------------------------------------------------------------------------
module vga_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic fall
);

  logic d_p1;
  logic d_p2;

  // Idle-high reset so a line that is already high never produces a strobe
  // straight out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      d_p1 <= 1'b1;
      d_p2 <= 1'b1;
    end else begin
      d_p1 <= d;
      d_p2 <= d_p1;
    end
  end

  assign fall = d_p2 & ~d_p1;

endmodule

// File: rtl/vga_sync_monitor.sv
// -----------------------------------------------------------------------------
// vga_sync_monitor
// Receive-side VGA timing checker. Recovers pixel coordinates from the sync
// edges, verifies every line and frame against nominal timing, locks after
// LOCK_FRAMES clean frames and captures the colour at one probe pixel.
//   clk_25MHz, reset              : pixel clock, synchronous active-high reset
//   hsync, vsync                  : monitored active-low syncs
//   red, green, blue              : monitored colour (4 bits each)
//   probe_x, probe_y              : probe coordinate, static while locked
//   locked                        : timing verified
//   x, y                          : recovered coordinate of the stage-1 sample
//   active_video                  : visible-area flag, gated by locked
//   frame_start                   : pulse at (0,0) while locked
//   timing_err, err_count         : violation pulse and saturating count
//   probe_red/green/blue          : last captured probe colour
//   probe_valid                   : pulse when the probe colour updates
// -----------------------------------------------------------------------------
module vga_sync_monitor #(
  parameter int H_ACTIVE    = vga_timing_pkg::H_ACTIVE,
  parameter int H_FP        = vga_timing_pkg::H_FP,
  parameter int H_SYNC      = vga_timing_pkg::H_SYNC,
  parameter int H_BP        = vga_timing_pkg::H_BP,
  parameter int V_ACTIVE    = vga_timing_pkg::V_ACTIVE,
  parameter int V_FP        = vga_timing_pkg::V_FP,
  parameter int V_SYNC      = vga_timing_pkg::V_SYNC,
  parameter int V_BP        = vga_timing_pkg::V_BP,
  parameter int LOCK_FRAMES = vga_timing_pkg::LOCK_FRAMES
) (
  input  logic       clk_25MHz,
  input  logic       reset,
  input  logic       hsync,
  input  logic       vsync,
  input  logic [3:0] red,
  input  logic [3:0] green,
  input  logic [3:0] blue,
  input  logic [9:0] probe_x,
  input  logic [9:0] probe_y,
  output logic       locked,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       active_video,
  output logic       frame_start,
  output logic       timing_err,
  output logic [7:0] err_count,
  output logic [3:0] probe_red,
  output logic [3:0] probe_green,
  output logic [3:0] probe_blue,
  output logic       probe_valid
);

  import vga_timing_pkg::*;

  localparam int         H_TOT  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int         V_TOT  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [9:0] X_LAST = 10'(H_TOT - 1);
  localparam logic [9:0] Y_LAST = 10'(V_TOT - 1);
  localparam logic [9:0] HS_AT  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] VS_AT  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] X_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] Y_ACT  = 10'(V_ACTIVE);
  localparam logic [7:0] LOCK_N = 8'(LOCK_FRAMES);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic       hs_fall, vs_fall;
  logic [3:0] red_p1, green_p1, blue_p1;

  mon_state_t state, state_nxt;
  logic [9:0] h_cnt, v_cnt;         // coordinate of the stage-1 sample
  logic       v_seen;               // vsync fall seen on the current VS line
  logic       bad_frame;            // violation since the last vsync fall
  logic [7:0] good_cnt, good_nxt;

  logic [9:0] cur_x, cur_y, nxt_x, nxt_y;
  logic       eol, h_viol, v_viol, viol;
  logic       v_seen_nxt, bad_nxt, lock_nxt, av_nxt, probe_hit;

  // ---- stage 1: input registers and falling-edge strobes ----
  vga_edge_detect u_hs_edge (
    .clk  (clk_25MHz),
    .rst  (reset),
    .d    (hsync),
    .fall (hs_fall)
  );

  vga_edge_detect u_vs_edge (
    .clk  (clk_25MHz),
    .rst  (reset),
    .d    (vsync),
    .fall (vs_fall)
  );

  always_ff @(posedge clk_25MHz) begin
    red_p1   <= red;
    green_p1 <= green;
    blue_p1  <= blue;
  end

  // A sync fall always defines the coordinate of the sample it lands on; in
  // HUNT that is the alignment itself, after a violation it is the realign,
  // and on a correct fall it changes nothing.
  always_comb begin
    cur_x = hs_fall ? HS_AT : h_cnt;
    cur_y = vs_fall ? VS_AT : v_cnt;
    eol   = (cur_x == X_LAST);
    nxt_x = eol ? 10'd0 : cur_x + 10'd1;
    nxt_y = cur_y;
    if (eol) begin
      nxt_y = (cur_y == Y_LAST) ? 10'd0 : cur_y + 10'd1;
    end

    h_viol = hs_fall ? (h_cnt != HS_AT) : (h_cnt == HS_AT);
    // A missing vsync is only declared on the last pixel of the VS line.
    v_viol = vs_fall ? (v_cnt != VS_AT)
                     : (eol && (cur_y == VS_AT) && !v_seen);
    viol   = (state != HUNT) && (h_viol || v_viol);

    v_seen_nxt = v_seen;
    if (vs_fall) begin
      v_seen_nxt = 1'b1;
    end else if (eol && (cur_y == VS_AT)) begin
      v_seen_nxt = 1'b0;
    end
    bad_nxt = vs_fall ? 1'b0 : (bad_frame | viol);
  end

  // Lock FSM: the violation check takes precedence over the lock threshold.
  always_comb begin
    state_nxt = state;
    good_nxt  = good_cnt;
    case (state)
      HUNT: begin
        if (vs_fall) begin
          state_nxt = ALIGN;
          good_nxt  = 8'd0;
        end
      end
      ALIGN: begin
        if (viol) begin
          good_nxt = 8'd0;
        end else if (vs_fall && !bad_frame) begin
          if (good_cnt + 8'd1 >= LOCK_N) begin
            state_nxt = LOCKED;
          end else begin
            good_nxt = good_cnt + 8'd1;
          end
        end
      end
      LOCKED: begin
        if (viol) begin
          state_nxt = HUNT;
        end
      end
      default: state_nxt = HUNT;
    endcase
  end

  always_comb begin
    lock_nxt  = (state_nxt == LOCKED);
    av_nxt    = lock_nxt && (cur_x < X_ACT) && (cur_y < Y_ACT);
    probe_hit = av_nxt && (cur_x == probe_x) && (cur_y == probe_y);
  end

  always_ff @(posedge clk_25MHz) begin
    if (reset) begin
      state     <= HUNT;
      h_cnt     <= 10'd0;
      v_cnt     <= 10'd0;
      v_seen    <= 1'b0;
      bad_frame <= 1'b0;
      good_cnt  <= 8'd0;
    end else begin
      state     <= state_nxt;
      h_cnt     <= nxt_x;
      v_cnt     <= nxt_y;
      v_seen    <= v_seen_nxt;
      bad_frame <= bad_nxt;
      good_cnt  <= good_nxt;
    end
  end

  // ---- stage 2: registered outputs ----
  always_ff @(posedge clk_25MHz) begin
    if (reset) begin
      locked       <= 1'b0;
      x            <= 10'd0;
      y            <= 10'd0;
      active_video <= 1'b0;
      frame_start  <= 1'b0;
      timing_err   <= 1'b0;
      err_count    <= 8'd0;
      probe_red    <= 4'd0;
      probe_green  <= 4'd0;
      probe_blue   <= 4'd0;
      probe_valid  <= 1'b0;
    end else begin
      locked       <= lock_nxt;
      x            <= cur_x;
      y            <= cur_y;
      active_video <= av_nxt;
      frame_start  <= lock_nxt && (cur_x == 10'd0) && (cur_y == 10'd0);
      timing_err   <= viol;
      if (viol) begin
        err_count <= sat_inc8(err_count);
      end
      probe_valid  <= probe_hit;
      if (probe_hit) begin
        probe_red   <= red_p1;
        probe_green <= green_p1;
        probe_blue  <= blue_p1;
      end
    end
  end

endmodule

// File: doc/vga_sync_monitor.md
# vga_sync_monitor

Receive-side counterpart of the VGA timing generator: samples the 640x480@60 sync and colour signals the display pipeline drives to the pins, recovers pixel coordinates from the sync edges, checks every line and frame against nominal timing, and captures the colour at one programmable probe pixel. It sits in the 25 MHz pixel domain alongside the VGA controller for on-board self-check and debug readout. It drives no pins.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- LOCK_FRAMES, 2, consecutive error-free frames required to lock
- clk_25MHz  in  1  pixel clock
- reset  in  1  synchronous, active-high
- hsync  in  1  monitored hsync, active-low
- vsync  in  1  monitored vsync, active-low
- red, green, blue  in  4 each  monitored colour
- probe_x, probe_y  in  10 each  probe coordinate, static while locked
- locked  out  1  timing verified
- x, y  out  10 each  recovered coordinate of the stage-1 sample
- active_video  out  1  x < H_ACTIVE and y < V_ACTIVE, gated by locked
- frame_start  out  1  one-cycle pulse at x=0, y=0 while locked
- timing_err  out  1  one-cycle pulse per detected violation
- err_count  out  8  saturating violation count
- probe_red, probe_green, probe_blue  out  4 each  last captured probe colour
- probe_valid  out  1  one-cycle pulse when the probe registers update

## Operation
- Stage 1 registers hsync, vsync and rgb. Falling edges are detected between stage 1 and its delayed copy.
- H_TOTAL = 800. V_TOTAL = 525. HS_POS = H_ACTIVE+H_FP = 656. VS_POS = V_ACTIVE+V_FP = 490.
- x is free-running mod H_TOTAL. y increments when x wraps, mod V_TOTAL.
- States:
  - HUNT (reset state): counters realign on every edge and no errors are counted.
    - An hsync fall forces x=HS_POS.
    - A vsync fall forces y=VS_POS and moves to ALIGN with good-frame count = 0.
  - ALIGN:
    - An hsync fall must land at x==HS_POS. A fall at any other x, or none when x==HS_POS, is a violation.
    - A vsync fall must land while y==VS_POS (any x). A fall on any other line, or none by the end of line VS_POS, is a violation.
    - Each vsync fall with no violation since the previous fall increments good-frame count.
    - Reaching LOCK_FRAMES moves to LOCKED.
  - LOCKED: same checks as ALIGN. Any violation moves to HUNT.
- On a violation:
  - timing_err pulses and err_count increments, saturating at 255.
  - The offending counter realigns as in HUNT.
  - In ALIGN, good-frame count clears.
- Violation and lock threshold in the same cycle: the violation wins and the block stays in ALIGN.
- Probe capture: while locked and active_video and x==probe_x and y==probe_y, the stage-1 rgb is loaded into probe_* and probe_valid pulses. A probe outside the active area never fires.
- Width rules: x and y are 10-bit unsigned. Comparisons use full width. All parameter-derived constants are computed at elaboration.

## Timing
- Reset values: locked=0, x=0, y=0, active_video=0, frame_start=0, timing_err=0, err_count=0, probe_*=0, probe_valid=0. State is HUNT.
- Reset has priority over all activity. A reset mid-frame drops lock and clears err_count at the next edge.
- Latency:
  - x, y, active_video and probe_* refer to inputs sampled 2 edges earlier.
  - timing_err fires 2 edges after the input edge that causes it.
- locked rises 1 cycle after the qualifying vsync fall is detected. It falls 1 cycle after a violation in LOCKED.
- All outputs are registered. No combinational input-to-output path.

## Structure
- Shared package vga_timing_pkg holds:
  - the 640x480 timing constants and derived totals (H_TOTAL, V_TOTAL, HS_POS, VS_POS);
  - the state enum HUNT/ALIGN/LOCKED.
- The VGA controller imports the same package.
- One natural sub-module: vga_edge_detect. It contains the input register, delay and falling-edge strobe and is instantiated for hsync and for vsync.

## Test plan
- Nominal 800x525 stream from the VGA controller:
  - ALIGN starts at the first vsync fall;
  - locked=1 one cycle after the third vsync fall;
  - err_count=0 and timing_err never pulses.
- Once locked, inject one hsync fall at x=600 on line 100:
  - timing_err pulses once and err_count=1;
  - the block returns to HUNT with locked=0;
  - relock occurs after 2 clean frames.
- Drop vsync for one frame:
  - violation at the end of line 490;
  - err_count increments once per missing frame.
- Probe at (639,479) with blue=4'hA at that pixel only:
  - probe_valid pulses once per frame;
  - probe_blue=4'hA.
- Probe at (700,10):
  - probe_valid never pulses.
- 300 consecutive bad lines: err_count holds at 255.
- Assert reset mid-frame while locked:
  - next cycle all outputs are at their reset values;
  - lock is reacquired after 3 vsync falls.
